// File: rtl/dcache_controller.sv
// Sequencing FSM for a direct-mapped, write-through, no-write-allocate data cache.
// Load hit completes 2 cycles after accept; a miss or store waits for memory, and a flush takes DEPTH+1 cycles.
// The CPU is stalled whenever the FSM is not in IDLE; memory requests are held until iMemReady.
module dcache_controller #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 32 - ADDRESS_WIDTH - 2
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iCpuReq,
  input  logic                     iCpuWe,
  input  logic [31:0]              iCpuAddr,
  input  logic [DATA_WIDTH-1:0]    iCpuWData,
  input  logic                     iFlush,
  output logic                     oCpuStall,
  output logic                     oCpuValid,
  output logic [DATA_WIDTH-1:0]    oCpuRData,
  output logic                     oFlushDone,
  output logic [ADDRESS_WIDTH-1:0] oArrIndex,
  input  logic [TAG_WIDTH-1:0]     iArrTag,
  input  logic                     iArrV,
  input  logic [DATA_WIDTH-1:0]    iArrData,
  output logic                     oArrWe,
  output logic [TAG_WIDTH-1:0]     oArrWTag,
  output logic                     oArrWV,
  output logic [DATA_WIDTH-1:0]    oArrWData,
  output logic                     oMemReq,
  output logic                     oMemWe,
  output logic [31:0]              oMemAddr,
  output logic [DATA_WIDTH-1:0]    oMemWData,
  input  logic                     iMemReady,
  input  logic [DATA_WIDTH-1:0]    iMemRData
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE_MEM, FLUSH} state_t;

  state_t                   state, next_state;
  logic [ADDRESS_WIDTH-1:0] flush_cnt;
  logic [29:0]              lat_word;   // latched word address (byte offset dropped)
  logic                     lat_we;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [TAG_WIDTH-1:0]     lat_tag;
  logic [ADDRESS_WIDTH-1:0] lat_idx;
  logic                     hit;
  logic                     accept;

  // Byte offset within the word is irrelevant to a word-granular cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^iCpuAddr[1:0];

  assign lat_idx   = lat_word[ADDRESS_WIDTH-1:0];
  assign lat_tag   = lat_word[29:ADDRESS_WIDTH];
  assign hit       = iArrV && (iArrTag == lat_tag);
  assign accept    = (state == IDLE) && !iFlush && iCpuReq;
  assign oCpuStall = (state != IDLE);

  // Next-state and array/memory strobes; every output defaults to 0 first.
  always_comb begin
    next_state = state;
    oArrIndex  = '0;
    oArrWe     = 1'b0;
    oArrWTag   = '0;
    oArrWV     = 1'b0;
    oArrWData  = '0;
    oMemReq    = 1'b0;
    oMemWe     = 1'b0;
    oMemAddr   = '0;
    oMemWData  = '0;
    case (state)
      IDLE: begin
        if (iFlush) begin
          next_state = FLUSH;
        end else if (iCpuReq) begin
          oArrIndex  = iCpuAddr[ADDRESS_WIDTH+1:2];
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        oArrIndex = lat_idx;
        if (lat_we) begin
          // Write-through: update the line only if it is already resident.
          if (hit) begin
            oArrWe    = 1'b1;
            oArrWTag  = lat_tag;
            oArrWV    = 1'b1;
            oArrWData = lat_wdata;
          end
          next_state = WRITE_MEM;
        end else begin
          next_state = hit ? IDLE : REFILL;
        end
      end
      REFILL: begin
        oArrIndex = lat_idx;
        oMemReq   = 1'b1;
        oMemAddr  = {lat_tag, lat_idx, 2'b00};
        if (iMemReady) begin
          oArrWe     = 1'b1;
          oArrWTag   = lat_tag;
          oArrWV     = 1'b1;
          oArrWData  = iMemRData;
          next_state = IDLE;
        end
      end
      WRITE_MEM: begin
        oArrIndex = lat_idx;
        oMemReq   = 1'b1;
        oMemWe    = 1'b1;
        oMemAddr  = {lat_tag, lat_idx, 2'b00};
        oMemWData = lat_wdata;
        if (iMemReady) next_state = IDLE;
      end
      FLUSH: begin
        oArrIndex = flush_cnt;
        oArrWe    = 1'b1;
        if (flush_cnt == LAST_IDX) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, request latch, flush counter and registered CPU-side pulses.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      lat_word   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      oCpuValid  <= 1'b0;
      oCpuRData  <= '0;
      oFlushDone <= 1'b0;
    end else begin
      state      <= next_state;
      oCpuValid  <= 1'b0;
      oFlushDone <= 1'b0;
      if (accept) begin
        lat_word  <= iCpuAddr[31:2];
        lat_we    <= iCpuWe;
        lat_wdata <= iCpuWData;
      end
      if (state == LOOKUP && !lat_we && hit) begin
        oCpuValid <= 1'b1;
        oCpuRData <= iArrData;
      end
      if (state == REFILL && iMemReady) begin
        oCpuValid <= 1'b1;
        oCpuRData <= iMemRData;
      end
      if (state == WRITE_MEM && iMemReady) begin
        oCpuValid <= 1'b1;
      end
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;   // wraps back to 0 on the last entry
        if (flush_cnt == LAST_IDX) oFlushDone <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural tag/valid/data array.
// Array read data appears one cycle after oArrIndex; writes land on the same edge.
// Memory is answered by hand a fixed number of cycles after oMemReq.
module tb_dcache_controller;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iCpuReq;
  logic        iCpuWe;
  logic [31:0] iCpuAddr;
  logic [31:0] iCpuWData;
  logic        iFlush;
  logic        oCpuStall;
  logic        oCpuValid;
  logic [31:0] oCpuRData;
  logic        oFlushDone;
  logic [3:0]  oArrIndex;
  logic [25:0] iArrTag;
  logic        iArrV;
  logic [31:0] iArrData;
  logic        oArrWe;
  logic [25:0] oArrWTag;
  logic        oArrWV;
  logic [31:0] oArrWData;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic        iMemReady;
  logic [31:0] iMemRData;

  int compared = 0;
  int mismatched = 0;

  dcache_controller dut (
    .iCLK(iCLK), .iRST(iRST),
    .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuWData(iCpuWData),
    .iFlush(iFlush), .oCpuStall(oCpuStall), .oCpuValid(oCpuValid), .oCpuRData(oCpuRData),
    .oFlushDone(oFlushDone), .oArrIndex(oArrIndex), .iArrTag(iArrTag), .iArrV(iArrV),
    .iArrData(iArrData), .oArrWe(oArrWe), .oArrWTag(oArrWTag), .oArrWV(oArrWV),
    .oArrWData(oArrWData), .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
    .oMemWData(oMemWData), .iMemReady(iMemReady), .iMemRData(iMemRData)
  );

  always #5 iCLK = ~iCLK;

  // Behavioural cache array: synchronous read of the presented index, write on strobe.
  logic [25:0] arr_tag  [16];
  logic        arr_v    [16];
  logic [31:0] arr_data [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      arr_tag[i] = '0; arr_v[i] = 1'b0; arr_data[i] = '0;
    end
    iArrTag = '0; iArrV = 1'b0; iArrData = '0;
  end
  always @(posedge iCLK) begin
    iArrTag  <= arr_tag[oArrIndex];
    iArrV    <= arr_v[oArrIndex];
    iArrData <= arr_data[oArrIndex];
    if (oArrWe) begin
      arr_tag[oArrIndex]  <= oArrWTag;
      arr_v[oArrIndex]    <= oArrWV;
      arr_data[oArrIndex] <= oArrWData;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue a load; on a miss, answer memory after 3 extra cycles with mem_data.
  task automatic do_load(input string name, input logic [31:0] addr, input bit exp_hit,
                         input logic [31:0] mem_data, input logic [31:0] exp_data);
    iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = addr; #1;
    chk({name, "_idx"}, 64'(oArrIndex), 64'(addr[5:2]));
    tick();
    iCpuReq = 1'b0;
    chk({name, "_lookup_stall"}, 64'(oCpuStall), 64'd1);
    chk({name, "_lookup_memreq"}, 64'(oMemReq), 64'd0);
    tick();
    if (!exp_hit) begin
      chk({name, "_refill_req"}, 64'(oMemReq), 64'd1);
      chk({name, "_refill_we"}, 64'(oMemWe), 64'd0);
      chk({name, "_refill_addr"}, 64'(oMemAddr), 64'({addr[31:2], 2'b00}));
      tick(); tick(); tick();
      chk({name, "_refill_hold"}, 64'(oMemReq), 64'd1);
      iMemReady = 1'b1; iMemRData = mem_data; #1;
      chk({name, "_arr_we"}, 64'(oArrWe), 64'd1);
      chk({name, "_arr_tag"}, 64'(oArrWTag), 64'(addr[31:6]));
      chk({name, "_arr_v"}, 64'(oArrWV), 64'd1);
      chk({name, "_arr_idx"}, 64'(oArrIndex), 64'(addr[5:2]));
      chk({name, "_arr_data"}, 64'(oArrWData), 64'(mem_data));
      tick();
      iMemReady = 1'b0; iMemRData = '0;
    end
    chk({name, "_valid"}, 64'(oCpuValid), 64'd1);
    chk({name, "_rdata"}, 64'(oCpuRData), 64'(exp_data));
    chk({name, "_stall_done"}, 64'(oCpuStall), 64'd0);
    chk({name, "_memreq_done"}, 64'(oMemReq), 64'd0);
  endtask

  // Issue a store; memory completes 3 cycles after the write request appears.
  task automatic do_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input bit exp_hit);
    logic [31:0] rd_before;
    rd_before = oCpuRData;
    iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = addr; iCpuWData = data;
    tick();
    iCpuReq = 1'b0; iCpuWe = 1'b0; iCpuWData = '0; #1;
    chk({name, "_lookup_arrwe"}, 64'(oArrWe), 64'(exp_hit));
    if (exp_hit) begin
      chk({name, "_lookup_wdata"}, 64'(oArrWData), 64'(data));
      chk({name, "_lookup_wtag"}, 64'(oArrWTag), 64'(addr[31:6]));
      chk({name, "_lookup_wv"}, 64'(oArrWV), 64'd1);
    end
    tick();
    chk({name, "_wm_req"}, 64'(oMemReq), 64'd1);
    chk({name, "_wm_we"}, 64'(oMemWe), 64'd1);
    chk({name, "_wm_addr"}, 64'(oMemAddr), 64'({addr[31:2], 2'b00}));
    chk({name, "_wm_data"}, 64'(oMemWData), 64'(data));
    chk({name, "_wm_arrwe"}, 64'(oArrWe), 64'd0);
    tick(); tick(); tick();
    iMemReady = 1'b1; #1;
    chk({name, "_wm_ready_arrwe"}, 64'(oArrWe), 64'd0);
    tick();
    iMemReady = 1'b0;
    chk({name, "_valid"}, 64'(oCpuValid), 64'd1);
    chk({name, "_rdata_kept"}, 64'(oCpuRData), 64'(rd_before));
    chk({name, "_stall_done"}, 64'(oCpuStall), 64'd0);
  endtask

  initial begin
    iRST = 1'b1; iCpuReq = 1'b0; iCpuWe = 1'b0; iCpuAddr = '0; iCpuWData = '0;
    iFlush = 1'b0; iMemReady = 1'b0; iMemRData = '0;
    tick(); tick();
    chk("rst_stall", 64'(oCpuStall), 64'd0);
    chk("rst_valid", 64'(oCpuValid), 64'd0);
    chk("rst_rdata", 64'(oCpuRData), 64'd0);
    chk("rst_fdone", 64'(oFlushDone), 64'd0);
    chk("rst_memreq", 64'(oMemReq), 64'd0);
    chk("rst_arrwe", 64'(oArrWe), 64'd0);
    chk("rst_idx", 64'(oArrIndex), 64'd0);
    iRST = 1'b0;
    tick();

    // 1: flush walk; a concurrent CPU request loses to iFlush and is ignored while flushing.
    iFlush = 1'b1; iCpuReq = 1'b1; iCpuAddr = 32'h44;
    tick();
    iFlush = 1'b0; iCpuReq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("flush_we_%0d", i), 64'(oArrWe), 64'd1);
      chk($sformatf("flush_v_%0d", i), 64'(oArrWV), 64'd0);
      chk($sformatf("flush_idx_%0d", i), 64'(oArrIndex), 64'(i));
      chk($sformatf("flush_stall_%0d", i), 64'(oCpuStall), 64'd1);
      chk($sformatf("flush_done_early_%0d", i), 64'(oFlushDone), 64'd0);
      tick();
    end
    chk("flush_done", 64'(oFlushDone), 64'd1);
    chk("flush_stall_end", 64'(oCpuStall), 64'd0);
    chk("flush_arrwe_end", 64'(oArrWe), 64'd0);
    tick();
    chk("flush_done_pulse", 64'(oFlushDone), 64'd0);

    // 2: cold miss then hit.
    do_load("ld44_miss", 32'h44, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("ld44_hit", 32'h44, 1'b1, 32'h0, 32'hDEADBEEF);

    // 3: conflicting tag at index 1 evicts, then 0x44 misses again.
    do_load("ld84_miss", 32'h84, 1'b0, 32'h0BADF00D, 32'h0BADF00D);
    do_load("ld44_remiss", 32'h44, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);

    // 4: store hit updates array and memory, then load hits new data.
    do_store("st44_hit", 32'h44, 32'h12345678, 1'b1);
    do_load("ld44_after_st", 32'h44, 1'b1, 32'h0, 32'h12345678);

    // 5: store miss writes memory only; following load refills.
    do_store("st100_miss", 32'h100, 32'hA5A5A5A5, 1'b0);
    do_load("ld100_miss", 32'h100, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // 6: reset in the middle of a refill abandons it.
    iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 32'h200;
    tick();
    iCpuReq = 1'b0;
    tick();
    chk("rstmid_req_before", 64'(oMemReq), 64'd1);
    iRST = 1'b1;
    tick();
    chk("rstmid_memreq", 64'(oMemReq), 64'd0);
    chk("rstmid_stall", 64'(oCpuStall), 64'd0);
    chk("rstmid_valid", 64'(oCpuValid), 64'd0);
    chk("rstmid_arrwe", 64'(oArrWe), 64'd0);
    iRST = 1'b0;
    iMemReady = 1'b1; iMemRData = 32'h11111111;
    tick();
    chk("rstmid_late_ready_valid", 64'(oCpuValid), 64'd0);
    chk("rstmid_late_ready_stall", 64'(oCpuStall), 64'd0);
    iMemReady = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing FSM for the direct-mapped data-cache array (tag/valid/data, 1-cycle synchronous read) between the CPU memory stage and main memory.
- Policy: write-through, no-write-allocate.
- Performs hit/miss compare, line refill on read miss, memory write for every store, and a full-array invalidate (flush) walk.

Parameters:
ADDRESS_WIDTH, 4, index bits; array depth DEPTH = 2**ADDRESS_WIDTH
DATA_WIDTH, 32, word width
TAG_WIDTH, 26, address bits above index; equals 32-ADDRESS_WIDTH-2

Ports:
iCLK  in  1  clock, all logic on rising edge
iRST  in  1  synchronous active-high reset
iCpuReq  in  1  CPU access request, sampled only in IDLE
iCpuWe  in  1  1=store, 0=load
iCpuAddr  in  32  byte address; index=[ADDRESS_WIDTH+1:2], tag=[31:ADDRESS_WIDTH+2]
iCpuWData  in  DATA_WIDTH  store data
iFlush  in  1  invalidate request, sampled only in IDLE
oCpuStall  out  1  high whenever state != IDLE
oCpuValid  out  1  one-cycle completion pulse (load or store)
oCpuRData  out  DATA_WIDTH  load data, valid with oCpuValid
oFlushDone  out  1  one-cycle pulse after last invalidate
oArrIndex  out  ADDRESS_WIDTH  array read/write index
iArrTag  in  TAG_WIDTH  array tag, one cycle after oArrIndex
iArrV  in  1  array valid bit, one cycle after oArrIndex
iArrData  in  DATA_WIDTH  array data, one cycle after oArrIndex
oArrWe  out  1  array write strobe
oArrWTag  out  TAG_WIDTH  tag to write
oArrWV  out  1  valid bit to write
oArrWData  out  DATA_WIDTH  data to write
oMemReq  out  1  memory request, held until iMemReady
oMemWe  out  1  memory write
oMemAddr  out  32  word-aligned address {tag,index,2'b00}
oMemWData  out  DATA_WIDTH  memory write data
iMemReady  in  1  memory completion; read data valid same cycle
iMemRData  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: state IDLE, flush counter 0, all outputs 0; latched request cleared.
- Reset during REFILL/WRITE_MEM/FLUSH: abandon the operation, oMemReq=0 next cycle, no oCpuValid or oFlushDone. Array contents are not cleared; software issues a flush.
- States: IDLE, LOOKUP, REFILL, WRITE_MEM, FLUSH.
- IDLE:
  - iFlush has priority over iCpuReq.
  - iFlush -> FLUSH.
  - Else iCpuReq: latch addr/we/wdata, drive oArrIndex=index -> LOOKUP.
- LOOKUP: hit = iArrV && (iArrTag == latched tag).
  - Load hit: register oCpuRData=iArrData, oCpuValid=1 next cycle -> IDLE. Load-hit latency is 2 cycles from the accept edge, and a new request may be accepted in the oCpuValid cycle.
  - Load miss -> REFILL.
  - Store hit: oArrWe=1 this cycle (tag unchanged, V=1, data=wdata) -> WRITE_MEM.
  - Store miss: no array write -> WRITE_MEM.
- REFILL:
  - Drive oMemReq=1, oMemWe=0, oMemAddr, stable until iMemReady (iMemReady may arrive in the first REFILL cycle).
  - On iMemReady, same cycle: oArrWe=1 (latched tag, V=1, iMemRData).
  - Next cycle: oCpuRData=iMemRData, oCpuValid=1 -> IDLE.
- WRITE_MEM:
  - Drive oMemReq=1, oMemWe=1, oMemAddr, oMemWData=wdata until iMemReady.
  - Next cycle: oCpuValid=1 (oCpuRData unchanged) -> IDLE.
- FLUSH:
  - One entry per cycle: oArrIndex=counter, oArrWe=1, oArrWV=0, oArrWTag/oArrWData=0. Counter runs 0..DEPTH-1; its wrap at DEPTH-1 exits.
  - Next cycle: oFlushDone=1 -> IDLE.
  - FLUSH lasts exactly DEPTH cycles; iCpuReq is ignored (CPU sees stall).
- oArrIndex holds the latched index in LOOKUP/REFILL/WRITE_MEM.
- oMemReq is never asserted outside REFILL/WRITE_MEM.
- At most one outstanding memory transaction.

Test Plan:
1. Reset, pulse iFlush -> 16 consecutive cycles oArrWe=1, oArrWV=0, oArrIndex 0..15; oFlushDone pulse on cycle 17; oCpuStall high cycles 1-16.
2. Load 0x00000044 after flush; memory gives iMemReady+0xDEADBEEF 3 cycles after oMemReq:
   - Response: oMemAddr=0x44, oMemWe=0.
   - Array write at index 1: tag 0x1, V=1.
   - oCpuValid with 0xDEADBEEF.
   - Reload 0x44 -> no oMemReq, oCpuValid 2 cycles after accept, 0xDEADBEEF.
3. Load 0x00000084 (index 1, tag 0x2) after scenario 2 -> miss, refill overwrites index 1 tag 0x2; subsequent load 0x44 misses again.
4. Store 0x12345678 to 0x44 while resident:
   - oArrWe in the LOOKUP cycle, then memory write addr 0x44 data 0x12345678.
   - oCpuValid.
   - Load 0x44 -> hit 0x12345678, no oMemReq.
5. Store to 0x100 (not resident) -> memory write only, oArrWe never high; following load 0x100 issues refill.
6. Assert iRST while oMemReq=1 in REFILL -> next cycle oMemReq=0, oCpuStall=0, oCpuValid=0, oArrWe=0.
